// File: rtl/ram16x4_arbiter.sv
// ram16x4_arbiter
// Shares one 16x4 synchronous-read RAM between a host port (A) and a sample
// logger port (B). Round-robin arbitration with an optional bounded lock lets
// one port run a burst of up to MAX_LOCK transfers. Each accepted transfer is
// registered onto the RAM command bus; read data comes back to the requesting
// port two edges after acceptance, as a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ena                     block enable (low = no new grants)
//   req_x/we_x/lock_x       per-port request, write flag, lock request
//   addr_x/wdata_x          per-port address and write data
//   gnt_x                   combinational accept (transfer on req & gnt at edge)
//   rvalid_x/rdata_x        read return pulse and data (data 0 when not valid)
//   ram_en/we/addr/wdata    registered command to the RAM macro
//   ram_rdata               RAM read data (one-cycle latency after command)
//   busy                    command on the bus or read return pending
module ram16x4_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = 4;
    // With MAX_LOCK = 1 the first locked grant already exhausts the budget,
    // so the arbiter never leaves UNLOCKED.
    localparam bit LOCK_ENTER_OK = (MAX_LOCK > 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED_A,
        ST_LOCKED_B
    } arb_state_t;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              ptr_b_q, ptr_b_d;        // 0 = A has priority, 1 = B

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              rd_tag_a_q, rd_tag_b_q;  // read on the RAM bus, by owner
    logic              rvalid_a_q, rvalid_b_q;

    logic              acc;
    logic              sel_lock;
    logic              owner_req;
    logic              owner_lock;
    logic [CNT_W-1:0]  cnt_inc;

    // Grant decode. Gated by rst_n so grants drop the moment reset asserts.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n && ena) begin
            case (state_q)
                ST_LOCKED_A: gnt_a = req_a;
                ST_LOCKED_B: gnt_b = req_b;
                default: begin
                    if (req_a && req_b) begin
                        gnt_a = !ptr_b_q;
                        gnt_b = ptr_b_q;
                    end else begin
                        gnt_a = req_a;
                        gnt_b = req_b;
                    end
                end
            endcase
        end
    end

    assign acc        = gnt_a | gnt_b;
    assign sel_lock   = gnt_b ? lock_b : lock_a;
    assign owner_req  = (state_q == ST_LOCKED_B) ? req_b  : req_a;
    assign owner_lock = (state_q == ST_LOCKED_B) ? lock_b : lock_a;
    assign cnt_inc    = lock_cnt_q + 1'b1;

    // Arbitration next state. The pointer always moves away from whoever was
    // just accepted, which also hands priority to the other port on any lock
    // exit caused by a transfer.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        ptr_b_d    = ptr_b_q;
        if (gnt_a) begin
            ptr_b_d = 1'b1;
        end else if (gnt_b) begin
            ptr_b_d = 1'b0;
        end
        case (state_q)
            ST_UNLOCKED: begin
                if (acc && sel_lock && LOCK_ENTER_OK) begin
                    state_d    = gnt_b ? ST_LOCKED_B : ST_LOCKED_A;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            default: begin
                // With ena low the lock is frozen, even if the owner drops req.
                if (ena) begin
                    if (!owner_req) begin
                        state_d    = ST_UNLOCKED;
                        lock_cnt_d = '0;
                    end else if (acc) begin
                        if (!owner_lock || cnt_inc == MAX_CNT) begin
                            state_d    = ST_UNLOCKED;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = cnt_inc;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            lock_cnt_q  <= '0;
            ptr_b_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_tag_a_q  <= 1'b0;
            rd_tag_b_q  <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_b_q    <= ptr_b_d;
            ram_en_q   <= acc;
            ram_we_q   <= acc & (gnt_b ? we_b : we_a);
            if (acc) begin
                ram_addr_q  <= gnt_b ? addr_b  : addr_a;
                ram_wdata_q <= gnt_b ? wdata_b : wdata_a;
            end
            rd_tag_a_q <= gnt_a & ~we_a;
            rd_tag_b_q <= gnt_b & ~we_b;
            // RAM samples the command on the next edge; its data is then
            // visible for exactly one cycle alongside this pulse.
            rvalid_a_q <= rd_tag_a_q;
            rvalid_b_q <= rd_tag_b_q;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign rdata_a   = rvalid_a_q ? ram_rdata : '0;
    assign rdata_b   = rvalid_b_q ? ram_rdata : '0;
    assign busy      = ram_en_q | rvalid_a_q | rvalid_b_q;

endmodule

// File: tb/tb_ram16x4_arbiter.sv
module tb_ram16x4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [3:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [3:0] rdata_a, rdata_b;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr, ram_wdata, ram_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram16x4_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .lock_a(lock_a), .lock_b(lock_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // Behavioural 16x4 RAM with registered read.
    logic [3:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        ram_rdata = 4'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic       ena, ra, rb, wa, wb, la, lb;
        logic [3:0] aa, ab, da, db;
        logic       ga, gb, en, we, va, vb;
        logic [3:0] xa, xb;
        logic       busy;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(
        input logic e, ra, rb, wa, wb, la, lb,
        input logic [3:0] aa, ab, da, db,
        input logic ga, gb, en, we, va, vb,
        input logic [3:0] xa, xb,
        input logic bz);
        vec_t v;
        v.ena = e; v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb; v.la = la; v.lb = lb;
        v.aa = aa; v.ab = ab; v.da = da; v.db = db;
        v.ga = ga; v.gb = gb; v.en = en; v.we = we; v.va = va; v.vb = vb;
        v.xa = xa; v.xb = xb; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ena = v.ena; req_a = v.ra; req_b = v.rb; we_a = v.wa; we_b = v.wb;
        lock_a = v.la; lock_b = v.lb; addr_a = v.aa; addr_b = v.ab;
        wdata_a = v.da; wdata_b = v.db;
    endtask

    task automatic idle_inputs();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    endtask

    initial begin
        // Columns: ena ra rb wa wb la lb aa ab da db | ga gb en we va vb xa xb busy
        // Write then read-back on port A.
        tbl[0]  = mk(1,1,0,1,0,0,0, 3,0,4'hA,0, 1,0,0,0,0,0,0,0,0);
        tbl[1]  = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,1,1,0,0,0,0,1);
        tbl[2]  = mk(1,1,0,0,0,0,0, 3,0,0,0,   1,0,0,0,0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,1,0,0,0,0,0,1);
        tbl[4]  = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,1,0,4'hA,0,1);
        // Preload addr1=5 (A) and addr2=C (B); pointer currently favours B.
        tbl[5]  = mk(1,1,1,1,1,0,0, 1,2,5,4'hC, 0,1,0,0,0,0,0,0,0);
        tbl[6]  = mk(1,1,0,1,0,0,0, 1,0,5,0,   1,0,1,1,0,0,0,0,1);
        // Six contending reads, grants alternate; first read follows a write.
        tbl[7]  = mk(1,1,1,0,0,0,0, 1,2,0,0,   0,1,1,1,0,0,0,0,1);
        tbl[8]  = mk(1,1,1,0,0,0,0, 1,2,0,0,   1,0,1,0,0,0,0,0,1);
        tbl[9]  = mk(1,1,1,0,0,0,0, 1,2,0,0,   0,1,1,0,0,1,0,4'hC,1);
        tbl[10] = mk(1,1,1,0,0,0,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[11] = mk(1,1,1,0,0,0,0, 1,2,0,0,   0,1,1,0,0,1,0,4'hC,1);
        tbl[12] = mk(1,1,1,0,0,0,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[13] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,1,0,0,1,0,4'hC,1);
        tbl[14] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,1,0,5,0,1);
        tbl[15] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0,0,0,0,0);
        // Lock held by A: 4 grants then forced hand-over to B, then A again.
        tbl[16] = mk(1,1,0,0,0,1,0, 1,0,0,0,   1,0,0,0,0,0,0,0,0);
        tbl[17] = mk(1,1,1,0,0,1,0, 1,2,0,0,   1,0,1,0,0,0,0,0,1);
        tbl[18] = mk(1,1,1,0,0,1,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[19] = mk(1,1,1,0,0,1,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[20] = mk(1,1,1,0,0,1,0, 1,2,0,0,   0,1,1,0,1,0,5,0,1);
        tbl[21] = mk(1,1,1,0,0,0,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        // Early release: lock for 2 transfers, released on the 3rd.
        tbl[22] = mk(1,1,0,0,0,1,0, 1,0,0,0,   1,0,1,0,0,1,0,4'hC,1);
        tbl[23] = mk(1,1,1,0,0,1,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[24] = mk(1,1,1,0,0,0,0, 1,2,0,0,   1,0,1,0,1,0,5,0,1);
        tbl[25] = mk(1,1,1,0,0,0,0, 1,2,0,0,   0,1,1,0,1,0,5,0,1);
        tbl[26] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,1,0,1,0,5,0,1);
        tbl[27] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0,1,0,4'hC,1);
        tbl[28] = mk(1,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0,0,0,0,0);

        rst_n = 0; ena = 0;
        idle_inputs();
        #1;
        chk("reset_gnt_a", {3'b0, gnt_a}, 4'h0);
        chk("reset_ram_en", {3'b0, ram_en}, 4'h0);
        chk("reset_busy", {3'b0, busy}, 4'h0);
        chk("reset_rvalid_a", {3'b0, rvalid_a}, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d_gnt_a", i),    {3'b0, gnt_a},    {3'b0, tbl[i].ga});
            chk($sformatf("row%0d_gnt_b", i),    {3'b0, gnt_b},    {3'b0, tbl[i].gb});
            chk($sformatf("row%0d_ram_en", i),   {3'b0, ram_en},   {3'b0, tbl[i].en});
            chk($sformatf("row%0d_ram_we", i),   {3'b0, ram_we},   {3'b0, tbl[i].we});
            chk($sformatf("row%0d_rvalid_a", i), {3'b0, rvalid_a}, {3'b0, tbl[i].va});
            chk($sformatf("row%0d_rvalid_b", i), {3'b0, rvalid_b}, {3'b0, tbl[i].vb});
            chk($sformatf("row%0d_rdata_a", i),  rdata_a,          tbl[i].xa);
            chk($sformatf("row%0d_rdata_b", i),  rdata_b,          tbl[i].xb);
            chk($sformatf("row%0d_busy", i),     {3'b0, busy},     {3'b0, tbl[i].busy});
            $display("row %0d: gnt_a=%b gnt_b=%b ram_en=%b rvalid_a=%b rdata_a=%h rvalid_b=%b rdata_b=%h busy=%b",
                     i, gnt_a, gnt_b, ram_en, rvalid_a, rdata_a, rvalid_b, rdata_b, busy);
        end

        // ena dropped the cycle after a read accept (pointer favours A here).
        @(negedge clk);
        idle_inputs(); ena = 1; req_a = 1; addr_a = 2;
        #1 chk("ena_first_gnt_a", {3'b0, gnt_a}, 4'h1);
        @(negedge clk);
        ena = 0; req_a = 1; req_b = 1; addr_a = 1; addr_b = 2;
        #1 chk("ena_off_gnt_a", {3'b0, gnt_a}, 4'h0);
        chk("ena_off_gnt_b", {3'b0, gnt_b}, 4'h0);
        chk("ena_off_ram_en", {3'b0, ram_en}, 4'h1);
        @(negedge clk); #1;
        chk("ena_off_rvalid_a", {3'b0, rvalid_a}, 4'h1);
        chk("ena_off_rdata_a", rdata_a, 4'hC);
        chk("ena_off_gnt_b2", {3'b0, gnt_b}, 4'h0);
        chk("ena_off_busy_pend", {3'b0, busy}, 4'h1);
        $display("ena seq: rvalid_a=%b rdata_a=%h busy=%b", rvalid_a, rdata_a, busy);
        @(negedge clk); #1;
        chk("ena_off_busy_drained", {3'b0, busy}, 4'h0);
        chk("ena_off_rvalid_a_done", {3'b0, rvalid_a}, 4'h0);
        @(negedge clk);
        ena = 1;
        #1 chk("ena_on_gnt_b", {3'b0, gnt_b}, 4'h1);
        chk("ena_on_gnt_a", {3'b0, gnt_a}, 4'h0);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset with a read in flight (pointer favours A again).
        req_a = 1; addr_a = 1;
        #1 chk("rst_seq_gnt_a", {3'b0, gnt_a}, 4'h1);
        @(negedge clk);
        idle_inputs();
        #1 chk("rst_seq_ram_en_pre", {3'b0, ram_en}, 4'h1);
        rst_n = 0; req_a = 1; req_b = 1;
        #1;
        chk("rst_seq_ram_en", {3'b0, ram_en}, 4'h0);
        chk("rst_seq_busy", {3'b0, busy}, 4'h0);
        chk("rst_seq_gnt_a", {3'b0, gnt_a}, 4'h0);
        chk("rst_seq_gnt_b", {3'b0, gnt_b}, 4'h0);
        chk("rst_seq_rvalid_a", {3'b0, rvalid_a}, 4'h0);
        $display("reset seq: ram_en=%b busy=%b gnt_a=%b gnt_b=%b", ram_en, busy, gnt_a, gnt_b);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst%0d_rvalid_a", k), {3'b0, rvalid_a}, 4'h0);
            chk($sformatf("post_rst%0d_rvalid_b", k), {3'b0, rvalid_b}, 4'h0);
            chk($sformatf("post_rst%0d_busy", k), {3'b0, busy}, 4'h0);
        end
        req_a = 1; req_b = 1; addr_a = 1; addr_b = 2;
        #1;
        chk("post_rst_gnt_a", {3'b0, gnt_a}, 4'h1);
        chk("post_rst_gnt_b", {3'b0, gnt_b}, 4'h0);
        @(negedge clk);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram16x4_arbiter.md
Name: ram16x4_arbiter

Overview:
- Shares the 16x4 synchronous-read playground RAM between two requesters: port A is the host path (ui_in/uio_in in MODE_RAM) and port B is the internal sample logger (FDC capture).
- Implements round-robin arbitration with an optional bounded lock for bursts.
- Registers one command per cycle into the RAM and returns read data with a fixed latency.
- Sits between the mode mux and the RAM macro inside tt_um_digital_playground.

Parameters:
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 4, RAM word width.
- MAX_LOCK, 4, maximum consecutive locked grants to one port before a forced hand-over; legal range 1..15.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; low = no new grants
- req_a / req_b  in  1  request valid, port A / B
- we_a / we_b  in  1  1 = write, 0 = read
- lock_a / lock_b  in  1  request to keep ownership after this grant
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  combinational accept; transfer occurs on a rising edge with req & gnt
- rvalid_a / rvalid_b  out  1  one-cycle read-data-valid pulse
- rdata_a / rdata_b  out  DATA_W  read data, valid while rvalid is high, 0 otherwise
- ram_en  out  1  registered RAM command valid
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data (registered inside RAM, 1-cycle latency)
- busy  out  1  high when ram_en is high or any rvalid is pending

Behaviour:
- Reset (async, rst_n low): all outputs 0; priority pointer = A; lock owner = none; lock count = 0; in-flight read tags cleared.
  - Any in-flight read is discarded; no rvalid after reset release.
- Handshake:
  - A requester holds req/we/addr/wdata stable until gnt.
  - At most one of gnt_a and gnt_b is high in any cycle.
  - gnt is never high when ena = 0 or when the corresponding req = 0.
- Arbitration states:
  - UNLOCKED:
    - Single requester: that port is granted.
    - Both requesting: the port named by the priority pointer is granted.
    - After every accepted transfer, the pointer moves to the other port.
  - LOCKED_X: entered when port X is accepted with lock_x = 1.
    - Only X can be granted; the other port sees gnt = 0.
    - Each accepted X transfer increments the lock count.
    - Exit to UNLOCKED when any of these occurs:
      - an X transfer is accepted with lock_x = 0;
      - the lock count reaches MAX_LOCK;
      - X drops req while in LOCKED_X.
    - On a forced MAX_LOCK exit, the pointer is set to the other port.
    - The count resets on exit.
- Command pipeline (one transfer accepted per cycle max, back-to-back allowed):
  - Edge E0 (accept): ram_en/we/addr/wdata register the winner's command; a read tag records the owner.
  - Edge E1: the RAM samples the command. For reads, ram_rdata updates.
  - The cycle after E1: rvalid_owner = 1 and rdata_owner = ram_rdata.
  - Read latency = 2 edges from acceptance.
  - Writes produce no rvalid.
  - ram_en = 0 in any cycle following an edge with no accepted transfer.
- Ordering:
  - Commands reach the RAM in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
- ena low: no new grants; commands already registered and pending rvalids still complete; lock state and pointer hold.
- Simultaneous events:
  - A locked owner requesting alongside the other port always wins until a lock exit condition occurs.
  - If lock_x = 1 on the very transfer that reaches MAX_LOCK, the arbiter still exits the lock.
- Address and data are passed unmodified; there is no wrap logic beyond the ADDR_W width.

Test Plan:
- Reset, then A writes 0xA to addr 3, then A reads addr 3 → gnt_a pulses on each transfer; ram_we = 1 one cycle after the write accept; rvalid_a = 1 with rdata_a = 0xA 2 edges after the read accept; rvalid_b stays 0.
- req_a and req_b held high for 6 reads (A on addr 1, B on addr 2, contents 0x5 and 0xC) → grants alternate A,B,A,B,A,B; rdata_a = 0x5 and rdata_b = 0xC on their respective rvalid pulses; ram_en high every cycle.
- A with lock_a = 1 continuously while B requests, MAX_LOCK = 4 → exactly 4 consecutive gnt_a, then gnt_b on the next cycle; afterwards the pointer favours A again.
- Lock released early: A with lock_a = 1 for 2 transfers then lock_a = 0 on the 3rd → 3 gnt_a, then B is granted on the next cycle.
- ena dropped the cycle after a read accept → no further grants while ena = 0; the pending rvalid still fires with correct data; busy falls to 0 once the pipeline drains.
- rst_n asserted while a read is in flight → ram_en, rvalid_*, gnt_* and busy go to 0 immediately; no rvalid after release; the first grant goes to A when both ports request.
